// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue unit: ALU op encodings, MIPS R-type funct codes,
// FSM state encoding and the operation kind used to pick the writeback source.
package alu_pkg;

    // ALU op encodings seen on alu_op
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;

    // MIPS R-type funct codes
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU = 6'h2B;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    // KindAlu: write alu_out; KindSet: write the compare bit; KindIllegal: write nothing
    typedef enum logic [1:0] {
        KindAlu,
        KindSet,
        KindIllegal
    } kind_e;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational MIPS funct decoder.
// Ports: funct (6-bit R-type funct) -> op (ALU op), unsig (unsigned compare),
//        kind (writeback source), trap_en (signed overflow traps), illegal (unsupported funct).
module alu_funct_decode
    import alu_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] op,
    output logic       unsig,
    output kind_e      kind,
    output logic       trap_en,
    output logic       illegal
);

    always_comb begin
        op      = ALU_AND;
        unsig   = 1'b0;
        kind    = KindIllegal;
        trap_en = 1'b0;
        illegal = 1'b1;
        unique case (funct)
            FUNCT_ADD:  begin op = ALU_ADD; kind = KindAlu; trap_en = 1'b1; illegal = 1'b0; end
            FUNCT_ADDU: begin op = ALU_ADD; kind = KindAlu; illegal = 1'b0; end
            FUNCT_SUB:  begin op = ALU_SUB; kind = KindAlu; trap_en = 1'b1; illegal = 1'b0; end
            FUNCT_SUBU: begin op = ALU_SUB; kind = KindAlu; illegal = 1'b0; end
            FUNCT_AND:  begin op = ALU_AND; kind = KindAlu; illegal = 1'b0; end
            FUNCT_OR:   begin op = ALU_OR;  kind = KindAlu; illegal = 1'b0; end
            FUNCT_XOR:  begin op = ALU_XOR; kind = KindAlu; illegal = 1'b0; end
            FUNCT_NOR:  begin op = ALU_NOR; kind = KindAlu; illegal = 1'b0; end
            // Compares only use alu_comp; op is parked on ADD
            FUNCT_SLT:  begin op = ALU_ADD; kind = KindSet; illegal = 1'b0; end
            FUNCT_SLTU: begin op = ALU_ADD; kind = KindSet; unsig = 1'b1; illegal = 1'b0; end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Requester side of an external combinational 32-bit ALU.
// Accepts one R-type request on req_*, drives registered operands/op on alu_*, captures the ALU
// result one cycle later and presents it on rsp_* until rsp_ready. ovf_count saturates.
// Ports: clk, reset_n (async active-low); req_valid/req_ready/req_funct/req_a/req_b/req_rd;
//        alu_a/alu_b/alu_op/alu_unsig out, alu_out/alu_comp/alu_ovf in;
//        rsp_valid/rsp_ready/rsp_data/rsp_rd/rsp_wen/rsp_ovf/rsp_illegal; ovf_count.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [5:0]       req_funct,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [4:0]       req_rd,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_op,
    output logic             alu_unsig,
    input  logic [31:0]      alu_out,
    input  logic             alu_comp,
    input  logic             alu_ovf,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [4:0]       rsp_rd,
    output logic             rsp_wen,
    output logic             rsp_ovf,
    output logic             rsp_illegal,
    output logic [CNT_W-1:0] ovf_count
);

    logic [2:0] dec_op;
    logic       dec_unsig;
    kind_e      dec_kind;
    logic       dec_trap_en;
    logic       dec_illegal;

    alu_funct_decode u_decode (
        .funct   (req_funct),
        .op      (dec_op),
        .unsig   (dec_unsig),
        .kind    (dec_kind),
        .trap_en (dec_trap_en),
        .illegal (dec_illegal)
    );

    state_e            state_q, state_d;
    logic [31:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]        alu_op_q, alu_op_d;
    logic              alu_unsig_q, alu_unsig_d;
    kind_e             kind_q, kind_d;
    logic              trap_q, trap_d;
    logic [4:0]        rd_q, rd_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic [4:0]        rsp_rd_q, rsp_rd_d;
    logic              rsp_wen_q, rsp_wen_d;
    logic              rsp_ovf_q, rsp_ovf_d;
    logic              rsp_illegal_q, rsp_illegal_d;
    logic [CNT_W-1:0]  ovf_count_q, ovf_count_d;

    logic exec_ovf;
    logic exec_illegal;

    always_comb begin
        state_d       = state_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        alu_unsig_d   = alu_unsig_q;
        kind_d        = kind_q;
        trap_d        = trap_q;
        rd_d          = rd_q;
        rsp_data_d    = rsp_data_q;
        rsp_rd_d      = rsp_rd_q;
        rsp_wen_d     = rsp_wen_q;
        rsp_ovf_d     = rsp_ovf_q;
        rsp_illegal_d = rsp_illegal_q;
        ovf_count_d   = ovf_count_q;
        exec_ovf      = alu_ovf && trap_q;
        exec_illegal  = (kind_q == KindIllegal);

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    // Illegal functs still load the ALU; the result is simply discarded
                    alu_a_d     = req_a;
                    alu_b_d     = req_b;
                    alu_op_d    = dec_op;
                    alu_unsig_d = dec_unsig;
                    kind_d      = dec_kind;
                    trap_d      = dec_trap_en && !dec_illegal;
                    rd_d        = req_rd;
                    state_d     = StExec;
                end
            end
            StExec: begin
                if (exec_illegal) begin
                    rsp_data_d = 32'h0;
                end else if (kind_q == KindSet) begin
                    rsp_data_d = {31'b0, alu_comp};
                end else begin
                    rsp_data_d = alu_out;
                end
                rsp_rd_d      = rd_q;
                rsp_ovf_d     = exec_ovf;
                rsp_illegal_d = exec_illegal;
                rsp_wen_d     = !exec_ovf && !exec_illegal;
                state_d       = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    if (rsp_ovf_q && (ovf_count_q != {CNT_W{1'b1}})) begin
                        ovf_count_d = ovf_count_q + 1'b1;
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= ALU_AND;
            alu_unsig_q   <= 1'b0;
            kind_q        <= KindAlu;
            trap_q        <= 1'b0;
            rd_q          <= '0;
            rsp_data_q    <= '0;
            rsp_rd_q      <= '0;
            rsp_wen_q     <= 1'b0;
            rsp_ovf_q     <= 1'b0;
            rsp_illegal_q <= 1'b0;
            ovf_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            alu_unsig_q   <= alu_unsig_d;
            kind_q        <= kind_d;
            trap_q        <= trap_d;
            rd_q          <= rd_d;
            rsp_data_q    <= rsp_data_d;
            rsp_rd_q      <= rsp_rd_d;
            rsp_wen_q     <= rsp_wen_d;
            rsp_ovf_q     <= rsp_ovf_d;
            rsp_illegal_q <= rsp_illegal_d;
            ovf_count_q   <= ovf_count_d;
        end
    end

    assign req_ready   = (state_q == StIdle);
    assign rsp_valid   = (state_q == StResp);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign alu_unsig   = alu_unsig_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_rd      = rsp_rd_q;
    assign rsp_wen     = rsp_wen_q;
    assign rsp_ovf     = rsp_ovf_q;
    assign rsp_illegal = rsp_illegal_q;
    assign ovf_count   = ovf_count_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural combinational ALU behind alu_*.
// CNT_W is shrunk to 2 so counter saturation is reachable in a few operations.
module tb_alu_issue_unit;

    localparam int unsigned CNT_W = 2;

    logic             clk;
    logic             reset_n;
    logic             req_valid;
    logic             req_ready;
    logic [5:0]       req_funct;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [4:0]       req_rd;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [2:0]       alu_op;
    logic             alu_unsig;
    logic [31:0]      alu_out;
    logic             alu_comp;
    logic             alu_ovf;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [4:0]       rsp_rd;
    logic             rsp_wen;
    logic             rsp_ovf;
    logic             rsp_illegal;
    logic [CNT_W-1:0] ovf_count;

    int n_checks = 0;
    int n_errors = 0;

    alu_issue_unit #(
        .CNT_W (CNT_W)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_funct   (req_funct),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_rd      (req_rd),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_unsig   (alu_unsig),
        .alu_out     (alu_out),
        .alu_comp    (alu_comp),
        .alu_ovf     (alu_ovf),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_rd      (rsp_rd),
        .rsp_wen     (rsp_wen),
        .rsp_ovf     (rsp_ovf),
        .rsp_illegal (rsp_illegal),
        .ovf_count   (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU
    logic [31:0] sum, diff;
    always_comb begin
        sum      = alu_a + alu_b;
        diff     = alu_a - alu_b;
        alu_out  = 32'h0;
        alu_ovf  = 1'b0;
        alu_comp = alu_unsig ? (alu_a < alu_b) : ($signed(alu_a) < $signed(alu_b));
        case (alu_op)
            3'b000: alu_out = alu_a & alu_b;
            3'b001: alu_out = alu_a | alu_b;
            3'b010: begin
                alu_out = sum;
                alu_ovf = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
            end
            3'b100: alu_out = ~(alu_a | alu_b);
            3'b101: alu_out = alu_a ^ alu_b;
            3'b110: begin
                alu_out = diff;
                alu_ovf = (alu_a[31] != alu_b[31]) && (diff[31] != alu_a[31]);
            end
            default: alu_out = 32'h0;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request and stop at the first RESP cycle (sampled on negedge).
    // Returns the op/unsig driven on the ALU during EXEC.
    task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output logic [2:0] op_seen,
                         output logic unsig_seen);
        int i;
        i = 0;
        @(negedge clk);
        while (!req_ready && i < 20) begin
            @(negedge clk);
            i++;
        end
        check_eq("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_funct = f;
        req_a     = a;
        req_b     = b;
        req_rd    = rd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        op_seen    = alu_op;
        unsig_seen = alu_unsig;
        check_eq("exec_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check_eq("exec_req_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        check_eq("resp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [2:0] op_s;
        logic       un_s;

        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_funct = 6'h0;
        req_a     = 32'h0;
        req_b     = 32'h0;
        req_rd    = 5'h0;
        rsp_ready = 1'b0;

        vecs[0] = '{6'h24, 32'hF0F0_1234, 32'h0FF0_FFFF, 3'b000, 32'h00F0_1234};
        vecs[1] = '{6'h25, 32'hF000_0001, 32'h0000_0F10, 3'b001, 32'hF000_0F11};
        vecs[2] = '{6'h26, 32'hAAAA_5555, 32'hFFFF_0000, 3'b101, 32'h5555_5555};
        vecs[3] = '{6'h27, 32'h0000_00FF, 32'h0F00_0000, 3'b100, 32'hF0FF_FF00};

        #12;
        check_eq("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check_eq("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check_eq("rst_rsp_wen", {31'b0, rsp_wen}, 32'd0);
        check_eq("rst_rsp_ovf", {31'b0, rsp_ovf}, 32'd0);
        check_eq("rst_rsp_illegal", {31'b0, rsp_illegal}, 32'd0);
        check_eq("rst_rsp_data", rsp_data, 32'h0);
        check_eq("rst_alu_a", alu_a, 32'h0);
        check_eq("rst_alu_b", alu_b, 32'h0);
        check_eq("rst_rsp_rd", {27'b0, rsp_rd}, 32'h0);
        check_eq("rst_alu_op", {29'b0, alu_op}, 32'h0);
        check_eq("rst_alu_unsig", {31'b0, alu_unsig}, 32'h0);
        check_eq("rst_ovf_count", {30'b0, ovf_count}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // ADDU: wraps silently
        do_op(6'h21, 32'h7FFF_FFFF, 32'h1, 5'd3, op_s, un_s);
        check_eq("addu_op", {29'b0, op_s}, 32'b010);
        check_eq("addu_data", rsp_data, 32'h8000_0000);
        check_eq("addu_ovf", {31'b0, rsp_ovf}, 32'd0);
        check_eq("addu_wen", {31'b0, rsp_wen}, 32'd1);
        check_eq("addu_rd", {27'b0, rsp_rd}, 32'd3);
        handshake();

        // ADD: traps, counter bumps only on handshake
        do_op(6'h20, 32'h7FFF_FFFF, 32'h1, 5'd4, op_s, un_s);
        check_eq("add_ovf", {31'b0, rsp_ovf}, 32'd1);
        check_eq("add_wen", {31'b0, rsp_wen}, 32'd0);
        check_eq("add_data", rsp_data, 32'h8000_0000);
        check_eq("add_cnt_before", {30'b0, ovf_count}, 32'd0);
        handshake();
        check_eq("add_cnt_after", {30'b0, ovf_count}, 32'd1);

        // SLT / SLTU
        do_op(6'h2A, 32'hFFFF_FFFF, 32'h1, 5'd5, op_s, un_s);
        check_eq("slt_unsig", {31'b0, un_s}, 32'd0);
        check_eq("slt_data", rsp_data, 32'h1);
        check_eq("slt_wen", {31'b0, rsp_wen}, 32'd1);
        handshake();
        do_op(6'h2B, 32'hFFFF_FFFF, 32'h1, 5'd6, op_s, un_s);
        check_eq("sltu_unsig", {31'b0, un_s}, 32'd1);
        check_eq("sltu_data", rsp_data, 32'h0);
        handshake();

        // Illegal funct
        do_op(6'h3F, 32'h7FFF_FFFF, 32'h1, 5'd7, op_s, un_s);
        check_eq("ill_flag", {31'b0, rsp_illegal}, 32'd1);
        check_eq("ill_wen", {31'b0, rsp_wen}, 32'd0);
        check_eq("ill_data", rsp_data, 32'h0);
        check_eq("ill_rd", {27'b0, rsp_rd}, 32'd7);
        check_eq("ill_ovf", {31'b0, rsp_ovf}, 32'd0);
        handshake();

        // Logic ops
        foreach (vecs[i]) begin
            do_op(vecs[i].f, vecs[i].a, vecs[i].b, 5'd9, op_s, un_s);
            check_eq($sformatf("logic%0d_op", i), {29'b0, op_s}, {29'b0, vecs[i].op});
            check_eq($sformatf("logic%0d_data", i), rsp_data, vecs[i].data);
            handshake();
        end

        // SUB with back-pressure; a competing request must not be accepted
        do_op(6'h22, 32'd5, 32'd7, 5'd10, op_s, un_s);
        req_valid = 1'b1;
        req_funct = 6'h21;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq("stall_valid", {31'b0, rsp_valid}, 32'd1);
            check_eq("stall_data", rsp_data, 32'hFFFF_FFFE);
            check_eq("stall_ready", {31'b0, req_ready}, 32'd0);
            check_eq("stall_ovf", {31'b0, rsp_ovf}, 32'd0);
        end
        req_valid = 1'b0;
        handshake();
        @(negedge clk);
        check_eq("post_stall_idle", {31'b0, req_ready}, 32'd1);
        check_eq("post_stall_valid", {31'b0, rsp_valid}, 32'd0);

        // Saturation: count is 1, three more traps -> 2, 3, 3
        for (int k = 0; k < 3; k++) begin
            do_op(6'h22, 32'h8000_0000, 32'h1, 5'd11, op_s, un_s);
            check_eq("sub_trap_ovf", {31'b0, rsp_ovf}, 32'd1);
            handshake();
        end
        check_eq("cnt_saturated", {30'b0, ovf_count}, 32'd3);

        // Reset during EXEC
        @(negedge clk);
        req_valid = 1'b1;
        req_funct = 6'h21;
        req_a     = 32'h1234_5678;
        req_b     = 32'h1;
        req_rd    = 5'd12;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("rst_exec_ready", {31'b0, req_ready}, 32'd1);
        check_eq("rst_exec_valid", {31'b0, rsp_valid}, 32'd0);
        check_eq("rst_exec_alu_a", alu_a, 32'h0);
        check_eq("rst_exec_data", rsp_data, 32'h0);
        check_eq("rst_exec_cnt", {30'b0, ovf_count}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        do_op(6'h21, 32'd2, 32'd3, 5'd13, op_s, un_s);
        check_eq("after_rst_data", rsp_data, 32'd5);
        check_eq("after_rst_rd", {27'b0, rsp_rd}, 32'd13);
        handshake();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
